// File: rtl/crc32_frame_arbiter.sv
// crc32_frame_arbiter: round-robin frame arbiter sharing one byte-parallel CRC-32 engine
// (poly 0x04C11DB7, MSB-first, non-reflected). Each granted frame is passed through byte
// by byte while the CRC accumulates, then the 4 CRC bytes are appended MSB first.
// Optional build macro CRC32_ARB_INIT_ONES_EN: init 0xFFFFFFFF and output XOR 0xFFFFFFFF
// (CRC-32/BZIP2). Undefined: init 0, no output XOR.
module crc32_frame_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_last,
   output logic [IDX_W-1:0]     out_src,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam logic [31:0] Poly = 32'h04C11DB7;
`ifdef CRC32_ARB_INIT_ONES_EN
   localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
   localparam logic [7:0]  XorOut  = 8'hFF;
`else
   localparam logic [31:0] CrcInit = 32'h0000_0000;
   localparam logic [7:0]  XorOut  = 8'h00;
`endif

   typedef enum logic [1:0] {StIdle, StData, StAppend} state_e;

   state_e           state_q;
   logic [31:0]      crc_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [2:0]       cnt_q;      // CRC bytes loaded into the output register so far
   logic             out_valid_q;
   logic [7:0]       out_data_q;
   logic             out_last_q;
   logic [IDX_W-1:0] out_src_q;

   logic             grant_any;
   logic [IDX_W-1:0] grant_idx;
   logic             sel_valid;
   logic             sel_last;
   logic [7:0]       sel_data;
   logic             slot_free;
   logic             accept;
   logic [31:0]      crc_next;
   logic [7:0]       crc_byte_out;
   logic [IDX_W-1:0] rr_next;

   // One byte of the CRC shift register; data bit 7 is folded in first against crc[31].
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[31] ^ d[i];
         r  = {r[30:0], 1'b0};
         if (fb) begin
            r = r ^ Poly;
         end
      end
      return r;
   endfunction

   // Round-robin pick: first valid requester at or after rr_ptr, modulo NUM_REQ.
   always_comb begin
      int idx;
      grant_any = 1'b0;
      grant_idx = '0;
      // Walk from farthest to nearest so the nearest valid requester wins.
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
         for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (j == idx && req_valid[j]) begin
               grant_any = 1'b1;
               grant_idx = IDX_W'(j);
            end
         end
      end
   end

   // Select the granted requester's stream and steer its ready.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = 8'h00;
      req_ready = '0;
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (IDX_W'(j) == out_src_q) begin
            sel_valid    = req_valid[j];
            sel_last     = req_last[j];
            sel_data     = req_data[8*j +: 8];
            req_ready[j] = (state_q == StData) && slot_free;
         end
      end
   end

   // Handshake helpers, CRC next state, and the CRC byte to emit next.
   always_comb begin
      slot_free = ~out_valid_q | out_ready;
      accept    = (state_q == StData) && sel_valid && slot_free;
      crc_next  = crc_byte(crc_q, sel_data);
      rr_next   = (out_src_q == IDX_W'(NUM_REQ - 1)) ? '0 : out_src_q + 1'b1;
      unique case (cnt_q[1:0])
         2'd0:    crc_byte_out = crc_q[31:24] ^ XorOut;
         2'd1:    crc_byte_out = crc_q[23:16] ^ XorOut;
         2'd2:    crc_byte_out = crc_q[15:8]  ^ XorOut;
         default: crc_byte_out = crc_q[7:0]   ^ XorOut;
      endcase
   end

   // Frame FSM with registered output byte; the output register only changes on a free slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         crc_q       <= CrcInit;
         rr_ptr_q    <= '0;
         cnt_q       <= 3'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  out_src_q <= grant_idx;
                  crc_q     <= CrcInit;
                  state_q   <= StData;
               end
            end
            StData: begin
               if (accept) begin
                  out_data_q  <= sel_data;
                  out_valid_q <= 1'b1;
                  crc_q       <= crc_next;
                  if (sel_last) begin
                     cnt_q   <= 3'd0;
                     state_q <= StAppend;
                  end
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            StAppend: begin
               if (cnt_q != 3'd4) begin
                  if (slot_free) begin
                     out_data_q  <= crc_byte_out;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (cnt_q == 3'd3);
                     cnt_q       <= cnt_q + 3'd1;
                  end
               end else if (out_ready) begin
                  // Final CRC byte taken: release the grant and rotate priority.
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  cnt_q       <= 3'd0;
                  rr_ptr_q    <= rr_next;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_crc32_frame_arbiter.sv
// Self-checking bench for crc32_frame_arbiter: per-requester byte sources, a scoreboard of
// expected output bytes, and an independent long-division CRC model.
module tb_crc32_frame_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam logic [31:0] Poly = 32'h04C11DB7;
`ifdef CRC32_ARB_INIT_ONES_EN
   localparam logic [31:0] ChkStr = 32'hFC891918;
   localparam logic [31:0] Xor32  = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] ChkStr = 32'h89A1897F;
   localparam logic [31:0] Xor32  = 32'h0000_0000;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    drv_valid;
   logic [N-1:0]    stall;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [7:0]      out_data;
   logic            out_last;
   logic [IW-1:0]   out_src;
   logic            out_ready;
   logic            busy;

   typedef struct packed {
      logic [7:0]    d;
      logic          l;
      logic [IW-1:0] s;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   logic [8:0] mem [N][64];
   int         head [N];
   int         tail [N];
   logic [N-1:0] fire;

   always #5 clk = ~clk;

   assign req_valid = drv_valid & ~stall;

   crc32_frame_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_last (req_last),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_last (out_last),
      .out_src  (out_src),
      .out_ready(out_ready),
      .busy     (busy)
   );

   // Augmented-message long division: remainder of (message * x^32) mod P.
   function automatic logic [31:0] crc_model(input logic [7:0] b [16], input int n);
      logic [32:0] r;
      logic [7:0]  by;
      logic        bit_v;
      r = '0;
      for (int t = 0; t < 8 * n + 32; t++) begin
         bit_v = 1'b0;
         if (t < 8 * n) begin
            by    = b[t / 8];
            bit_v = by[7 - (t % 8)];
         end
`ifdef CRC32_ARB_INIT_ONES_EN
         if (t < 32) bit_v = ~bit_v;
`endif
         r = {r[31:0], bit_v};
         if (r[32]) r = r ^ {1'b1, Poly};
      end
      return r[31:0] ^ Xor32;
   endfunction

   // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
   always @(negedge clk) begin
      fire = req_valid & req_ready;
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (fire[i]) head[i]++;
         if (head[i] < tail[i]) begin
            drv_valid[i]       = 1'b1;
            req_data[8*i +: 8] = mem[i][head[i]][7:0];
            req_last[i]        = mem[i][head[i]][8];
         end else begin
            drv_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      fire = '0;
   end

   // Scoreboard: every output handshake must match the next expected byte.
   always @(negedge clk) begin
      exp_t e;
      if (rst && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got data=%h last=%b src=%0d, required no output",
                     out_data, out_last, out_src);
         end else begin
            e = sb.pop_front();
            if ({out_data, out_last, out_src} !== {e.d, e.l, e.s}) begin
               bad++;
               $display("FAIL sb_byte: got data=%h last=%b src=%0d, required data=%h last=%b src=%0d",
                        out_data, out_last, out_src, e.d, e.l, e.s);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic load_frame(input int src, input logic [7:0] b [16], input int n,
                             input logic [31:0] crc, input int ncrc);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         mem[src][tail[src]] = {(k == n - 1), b[k]};
         tail[src]++;
         e.d = b[k];
         e.l = 1'b0;
         e.s = IW'(src);
         sb.push_back(e);
      end
      for (int k = 0; k < ncrc; k++) begin
         e.d = crc[31 - 8*k -: 8];
         e.l = (k == 3);
         e.s = IW'(src);
         sb.push_back(e);
      end
   endtask

   task automatic flush_sources();
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      drv_valid = '0;
      stall     = '0;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int c;
      c = 0;
      while (sb.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d bytes still expected, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      flush_sources();
      req_data  = '0;
      req_last  = '0;
      out_ready = 1'b0;
      rst       = 1'b0;
      repeat (2) @(negedge clk);
      total += 6;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", out_valid); end
      if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h required 00", out_data); end
      if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b required 0", out_last); end
      if (out_src !== '0) begin bad++; $display("FAIL rst_src: got %0d required 0", out_src); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
      if (req_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b required 0", req_ready); end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_single_byte();
      logic [7:0]  b [16];
      logic [31:0] crc;
      int          c;
      b[0] = 8'h01;
`ifdef CRC32_ARB_INIT_ONES_EN
      crc = crc_model(b, 1);
`else
      crc = 32'h04C11DB7;
`endif
      @(posedge clk);
      #1 out_ready = 1'b1;
      load_frame(0, b, 1, crc, 4);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(out_valid && out_ready && out_last) && c < 50);
      total++;
      if (c >= 50) begin
         bad++;
         $display("FAIL single_last: no out_last handshake in 50 cycles, required one");
      end
      @(negedge clk);
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b required 0", busy); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b required 0", out_valid); end
      wait_drain(20, "single");
   endtask

   task automatic test_check_string();
      logic [7:0] b [16];
      for (int k = 0; k < 9; k++) b[k] = 8'h31 + 8'(k);
      @(posedge clk);
      #1 load_frame(2, b, 9, ChkStr, 4);
      wait_drain(100, "check_string");
   endtask

   task automatic test_round_robin();
      logic [7:0] b [16];
      int lasts, idle, c;
      logic started;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int s = 0; s < N; s++) begin
         b[0] = 8'h10 + 8'(s);
         b[1] = 8'hE0 + 8'(s);
         load_frame(s, b, 2, crc_model(b, 2), 4);
      end
      b[0] = 8'h5A;
      b[1] = 8'hA5;
      load_frame(0, b, 2, crc_model(b, 2), 4);
      lasts   = 0;
      idle    = 0;
      c       = 0;
      started = 1'b0;
      while (lasts < 5 && c < 200) begin
         @(negedge clk);
         c++;
         if (busy) started = 1'b1;
         if (started && !busy) idle++;
         if (out_valid && out_ready && out_last) lasts++;
      end
      total += 2;
      if (lasts != 5) begin bad++; $display("FAIL rr_frames: got %0d frames required 5", lasts); end
      if (idle != 4) begin bad++; $display("FAIL rr_idle: got %0d idle cycles required 4", idle); end
      wait_drain(20, "round_robin");
   endtask

   task automatic test_backpressure();
      logic [7:0] b [16];
      logic [7:0] prev;
      logic       stalled;
      int         hs, c;
      b[0] = 8'hAA;
      b[1] = 8'hBB;
      b[2] = 8'h00;
      @(posedge clk);
      #1 load_frame(1, b, 3, crc_model(b, 3), 4);
      hs      = 0;
      c       = 0;
      stalled = 1'b0;
      prev    = 8'h00;
      while (hs < 7 && c < 100) begin
         @(negedge clk);
         c++;
         if (stalled) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== prev) begin
               bad++;
               $display("FAIL bp_hold: got valid=%b data=%h required valid=1 data=%h",
                        out_valid, out_data, prev);
            end
         end
         stalled = out_valid && !out_ready;
         prev    = out_data;
         if (out_valid && out_ready) hs++;
         if (hs < 7) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
         end
      end
      total++;
      if (hs != 7) begin bad++; $display("FAIL bp_handshakes: got %0d required 7", hs); end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain(20, "backpressure");
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_tail: got valid=%b required 0", out_valid); end
   endtask

   task automatic test_stall();
      logic [7:0] b [16];
      int c;
      for (int k = 0; k < 6; k++) b[k] = 8'h01 + 8'(k) * 8'h13;
      @(posedge clk);
      #1 load_frame(1, b, 6, crc_model(b, 6), 4);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(out_valid && out_src == 2'd1) && c < 50);
      @(posedge clk);
      #1 stall[1] = 1'b1;
      b[0] = 8'hC3;
      b[1] = 8'h3C;
      load_frame(3, b, 2, crc_model(b, 2), 4);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total += 2;
         if (req_ready[3] !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready3: got %b required 0", req_ready[3]);
         end
         if (out_src !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_grant: got src=%0d busy=%b required src=1 busy=1", out_src, busy);
         end
      end
      @(posedge clk);
      #1 stall[1] = 1'b0;
      wait_drain(100, "stall");
   endtask

   task automatic test_reset_mid_append();
      logic [7:0]  b [16];
      logic [31:0] crc;
      int          hs, c;
      b[0] = 8'h11;
      b[1] = 8'h22;
      b[2] = 8'h33;
      @(posedge clk);
      #1 load_frame(0, b, 3, crc_model(b, 3), 2);
      hs = 0;
      c  = 0;
      while (hs < 5 && c < 60) begin
         @(negedge clk);
         c++;
         if (out_valid && out_ready) hs++;
      end
      total++;
      if (hs != 5) begin bad++; $display("FAIL rma_progress: got %0d handshakes required 5", hs); end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      total += 6;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rma_valid: got %b required 0", out_valid); end
      if (out_data !== 8'h00) begin bad++; $display("FAIL rma_data: got %h required 00", out_data); end
      if (out_last !== 1'b0) begin bad++; $display("FAIL rma_last: got %b required 0", out_last); end
      if (out_src !== '0) begin bad++; $display("FAIL rma_src: got %0d required 0", out_src); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rma_busy: got %b required 0", busy); end
      if (req_ready !== '0) begin bad++; $display("FAIL rma_ready: got %b required 0", req_ready); end
      flush_sources();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL rma_pending: got %0d unseen bytes required 0", sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 4; k++) b[k] = 8'h00;
`ifdef CRC32_ARB_INIT_ONES_EN
      crc = crc_model(b, 4);
`else
      crc = 32'h0000_0000;
`endif
      load_frame(0, b, 4, crc, 4);
      wait_drain(60, "reset_recover");
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rma_end_busy: got %b required 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_check_string();
      test_round_robin();
      test_backpressure();
      test_stall();
      test_reset_mid_append();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
